// File: rtl/spart_pkg.sv
// Shared types and constants for the SPART serial port blocks.
package spart_pkg;

  localparam int unsigned SPART_OVS_DEFAULT = 16;
  localparam int unsigned SPART_DATA_BITS   = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

endpackage

// File: rtl/spart_rx_if.sv
// Pin-side and bus-side signals of the SPART receive datapath.
interface spart_rx_if;
  import spart_pkg::*;

  logic                       rxd;
  logic                       baud_en16;
  logic                       rd_strobe;
  logic [SPART_DATA_BITS-1:0] rx_data;
  logic                       rda;
  logic                       framing_err;
  logic                       overrun;

  modport master (
    output rxd, baud_en16, rd_strobe,
    input  rx_data, rda, framing_err, overrun
  );

  modport slave (
    input  rxd, baud_en16, rd_strobe,
    output rx_data, rda, framing_err, overrun
  );

endinterface

// File: rtl/spart_sync.sv
// N-flop synchronizer for asynchronous inputs; resets to the idle-high level.
module spart_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (!rst) ff <= '1;
    else      ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/spart_rx.sv
// SPART 8N1 receiver: oversampled start/data/stop recovery with one-byte
// buffer and ready / framing-error / overrun status.
module spart_rx
  import spart_pkg::*;
#(
  parameter int unsigned OVS         = SPART_OVS_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  spart_rx_if.slave   bus
);

  localparam int unsigned TW = $clog2(OVS);
  localparam int unsigned BW = $clog2(SPART_DATA_BITS);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVS - 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVS / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(SPART_DATA_BITS - 1);

  rx_state_e                  state;
  logic [TW-1:0]              tick_cnt;
  logic [BW-1:0]              bit_cnt;
  logic [SPART_DATA_BITS-1:0] shreg;
  logic                       rxs;
  logic                       load;

  spart_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.rxd),
    .q   (rxs)
  );

  assign load = bus.baud_en16 && (state == STOP) && (tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= IDLE;
      tick_cnt        <= '0;
      bit_cnt         <= '0;
      shreg           <= '0;
      bus.rx_data     <= '0;
      bus.rda         <= 1'b0;
      bus.framing_err <= 1'b0;
      bus.overrun     <= 1'b0;
    end else begin
      if (bus.baud_en16) begin
        case (state)
          IDLE: begin
            if (!rxs) begin
              state    <= START;
              tick_cnt <= '0;
            end
          end
          START: begin
            if (tick_cnt == TICK_MID) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              state    <= rxs ? IDLE : DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          DATA: begin
            if (tick_cnt == TICK_LAST) begin
              shreg    <= {rxs, shreg[SPART_DATA_BITS-1:1]};
              tick_cnt <= '0;
              bit_cnt  <= bit_cnt + 1'b1;
              if (bit_cnt == BIT_LAST) state <= STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          STOP: begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              state    <= IDLE;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end

      // A load coinciding with a CPU read keeps rda set and discards any overrun.
      if (load) begin
        bus.rx_data     <= shreg;
        bus.rda         <= 1'b1;
        bus.framing_err <= ~rxs;
        bus.overrun     <= bus.rd_strobe ? 1'b0 : (bus.overrun | bus.rda);
      end else if (bus.rd_strobe) begin
        bus.rda     <= 1'b0;
        bus.overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spart_rx.sv
// Directed self-checking bench for spart_rx at OVS=16 with baud_en16 held high.
module tb_spart_rx;
  import spart_pkg::*;

  localparam int unsigned OVS = 16;
  localparam int FRAME_CYC = 10 * OVS;
  // With baud_en16 always high, the mid-stop load lands on the 155th rising
  // edge counted from the start-bit drive (2 sync + 1 detect + 8 + 9*16).
  localparam int MID_STOP = 155;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  spart_rx_if bus ();

  spart_rx #(.OVS(OVS), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                            input int strobe_at, input int rst_at);
    for (int cyc = 1; cyc <= FRAME_CYC; cyc++) begin
      int j;
      j = (cyc - 1) / OVS;
      @(negedge clk);
      if (j == 0)      bus.rxd = 1'b0;
      else if (j <= 8) bus.rxd = data[j-1];
      else             bus.rxd = stop_bit;
      bus.rd_strobe = (cyc == strobe_at);
      rst           = (cyc == rst_at) ? 1'b0 : 1'b1;
    end
    @(negedge clk);
    bus.rxd       = 1'b1;
    bus.rd_strobe = 1'b0;
    rst           = 1'b1;
  endtask

  task automatic pulse_rd();
    @(negedge clk);
    bus.rd_strobe = 1'b1;
    @(negedge clk);
    bus.rd_strobe = 1'b0;
  endtask

  task automatic check_out(input string name, input logic [7:0] exp_data,
                           input logic exp_rda, input logic exp_fe, input logic exp_ov);
    checks++;
    if (bus.rx_data !== exp_data) begin
      errors++;
      $display("FAIL %s rx_data: got %h expected %h", name, bus.rx_data, exp_data);
    end
    checks++;
    if (bus.rda !== exp_rda) begin
      errors++;
      $display("FAIL %s rda: got %b expected %b", name, bus.rda, exp_rda);
    end
    checks++;
    if (bus.framing_err !== exp_fe) begin
      errors++;
      $display("FAIL %s framing_err: got %b expected %b", name, bus.framing_err, exp_fe);
    end
    checks++;
    if (bus.overrun !== exp_ov) begin
      errors++;
      $display("FAIL %s overrun: got %b expected %b", name, bus.overrun, exp_ov);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle(3);
    check_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    checks++;
    if (dut.state !== IDLE) begin
      errors++;
      $display("FAIL reset state: got %0d expected %0d", dut.state, IDLE);
    end
    rst = 1'b1;
    idle(4);
  endtask

  task automatic test_start_glitch();
    @(negedge clk);
    bus.rxd = 1'b0;
    idle(4);
    bus.rxd = 1'b1;
    idle(40);
    checks++;
    if (dut.state !== IDLE) begin
      errors++;
      $display("FAIL glitch state: got %0d expected %0d", dut.state, IDLE);
    end
    check_out("glitch", 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_frame_55();
    send_frame(8'h55, 1'b1, -1, -1);
    check_out("frame_55", 8'h55, 1'b1, 1'b0, 1'b0);
    pulse_rd();
    check_out("frame_55_read", 8'h55, 1'b0, 1'b0, 1'b0);
    idle(8);
  endtask

  task automatic test_framing_error();
    send_frame(8'hA3, 1'b0, -1, -1);
    check_out("framing", 8'hA3, 1'b1, 1'b1, 1'b0);
    idle(32);
    pulse_rd();
    check_out("framing_read", 8'hA3, 1'b0, 1'b1, 1'b0);
    idle(8);
  endtask

  task automatic test_overrun();
    send_frame(8'h12, 1'b1, -1, -1);
    send_frame(8'h34, 1'b1, -1, -1);
    check_out("overrun", 8'h34, 1'b1, 1'b0, 1'b1);
    pulse_rd();
    check_out("overrun_read", 8'h34, 1'b0, 1'b0, 1'b0);
    idle(8);
  endtask

  task automatic test_collision();
    send_frame(8'h5A, 1'b1, -1, -1);
    check_out("collision_first", 8'h5A, 1'b1, 1'b0, 1'b0);
    idle(8);
    send_frame(8'h7E, 1'b1, MID_STOP, -1);
    check_out("collision", 8'h7E, 1'b1, 1'b0, 1'b0);
    idle(8);
  endtask

  task automatic test_reset_mid_frame();
    // cycle 88 falls inside data bit 4 (cycles 81..96)
    send_frame(8'hFF, 1'b1, -1, 88);
    idle(200);
    check_out("reset_mid", 8'h00, 1'b0, 1'b0, 1'b0);
    send_frame(8'h0F, 1'b1, -1, -1);
    check_out("after_reset", 8'h0F, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    bus.rxd       = 1'b1;
    bus.baud_en16 = 1'b1;
    bus.rd_strobe = 1'b0;
    test_reset();
    test_start_glitch();
    test_frame_55();
    test_framing_error();
    test_overrun();
    test_collision();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spart_rx.md
Name: spart_rx

Overview:
- Receive datapath for the SPART serial port: turns the asynchronous RS232 `rxd` line into bytes for the bus-interface logic that raises `rda` to the driver.
- Sits between the pin and the SPART databus mux.
- Frame format is 8N1, oversampled at 16x baud using a one-cycle enable supplied by the SPART baud generator.
- Holds one received byte with ready, framing-error and overrun status.

Parameters:
- OVS, 16, oversample ticks per bit; must be even and ≥4.
- SYNC_STAGES, 2, flops in the `rxd` synchronizer; must be ≥2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-low reset; sampled on the rising edge of `clk`.
- rxd  input  1  raw asynchronous serial input; idle high.
- baud_en16  input  1  one-`clk` pulse at OVS x baud rate; all bit timing advances only on this pulse.
- rd_strobe  input  1  one-cycle pulse from the bus interface when the CPU reads the receive buffer.
- rx_data  output  8  last completed byte, LSB received first.
- rda  output  1  receive data available.
- framing_err  output  1  stop bit of the byte in `rx_data` sampled low.
- overrun  output  1  sticky flag: a byte completed while `rda` was already 1.

Behaviour:
- Reset (`rst`=0 at a `clk` edge):
  - state=IDLE, tick and bit counters=0, shift register=0.
  - Synchronizer flops=1.
  - `rx_data`=8'h00, `rda`=0, `framing_err`=0, `overrun`=0.
  - Reset mid-frame abandons the frame; no partial byte is ever loaded.
- Synchronizer: `rxd` passes through SYNC_STAGES flops. In the rules below, `rxs` is the synchronizer output.
- All counters and state move only on edges where `baud_en16`=1. Other edges hold everything except the `rd_strobe` effects.
- IDLE:
  - On a tick with `rxs`=0: go to START, tick_cnt=0.
- START:
  - tick_cnt increments each tick.
  - When tick_cnt=OVS/2-1 (mid start bit), sample `rxs`.
  - `rxs`=0: go to DATA, tick_cnt=0, bit_cnt=0.
  - `rxs`=1: glitch, return to IDLE, no status change.
- DATA:
  - tick_cnt increments each tick.
  - When tick_cnt=OVS-1: sample `rxs` into shift register MSB, shift right, tick_cnt=0, bit_cnt+1.
  - After the 8th sample: go to STOP.
- STOP:
  - When tick_cnt=OVS-1 (mid stop bit): load `rx_data`<=shift register, `rda`<=1, `framing_err`<=~`rxs`.
  - `overrun`<=1 if `rda` was 1 and `rd_strobe`=0 on that edge.
  - Go to IDLE on the same edge, so the next start edge is detected from mid-stop onward.
- Bad frames still load `rx_data`, with `framing_err`=1.
- `rd_strobe`=1 with no load on the same edge: `rda`<=0, `overrun`<=0. `rx_data` and `framing_err` hold.
- Load and `rd_strobe` on the same edge: the load wins. `rda` stays 1, `overrun` is not set, and an existing `overrun` clears.
- Latency: the frame's falling edge reaches `rxs` after SYNC_STAGES `clk` cycles. `rda` rises on the `clk` edge of the mid-stop tick, which is 9.5 bit-times plus at most one tick after the start edge.
- All outputs are registered; no combinational path from `rxd` or `rd_strobe` to any output.

Decomposition:
- spart_pkg holds:
  - the rx state enum (IDLE, START, DATA, STOP);
  - the constants SPART_OVS_DEFAULT=16 and SPART_DATA_BITS=8.
- One sub-module, spart_sync: a parameterized N-flop synchronizer with reset value 1. It is reused for the CTS-style inputs later.

Test Plan:
- Frame 0x55: `baud_en16` every cycle, OVS=16, each bit held 16 cycles, stop=1 -> `rx_data`=8'h55, `rda`=1, `framing_err`=0, `overrun`=0.
- Start glitch: `rxd` low for 4 cycles then high, `baud_en16` every cycle -> state returns to IDLE, `rda` stays 0.
- Framing error: frame 0xA3 with stop bit 0 -> `rx_data`=8'hA3, `rda`=1, `framing_err`=1.
- Overrun: two back-to-back frames 0x12 and 0x34 with no `rd_strobe` -> `rx_data`=8'h34, `overrun`=1. Then `rd_strobe` -> `rda`=0, `overrun`=0, `rx_data` still 8'h34.
- Collision: `rd_strobe` asserted on the exact mid-stop edge of a second frame 0x7E -> `rda`=1, `rx_data`=8'h7E, `overrun`=0.
- Reset mid-frame: `rst`=0 for 1 cycle during DATA bit 4 of 0xFF, then an idle line -> `rda`=0, `rx_data`=8'h00. A following frame 0x0F is received correctly.
